// File: rtl/pad_bridge_pkg.sv
`default_nettype none
// ==========================================================================
// pad_bridge_pkg : pad bit map, FSM state types and parity helper shared by
//                  the pad_handshake_bridge files.             Rev 1.0
// ==========================================================================
package pad_bridge_pkg;

  localparam int PAD_W       = 17;
  localparam int RX_DATA_LSB = 0;
  localparam int RX_REQ_BIT  = 8;
  localparam int TX_ACK_BIT  = 9;
  localparam int PAR_BIT     = 10;
  localparam int TX_DATA_LSB = 0;
  localparam int TX_REQ_BIT  = 8;
  localparam int RX_ACK_BIT  = 9;
  localparam int UNUSED_LSB  = 11;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    R_SYNC = 2'd0,
    R_IDLE = 2'd1,
    R_ACK  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_SETUP = 2'd1,
    T_REQ   = 2'd2,
    T_REL   = 2'd3
  } tx_state_e;

  // Odd parity: data plus parity bit carries an odd number of ones.
  function automatic logic odd_parity(input byte_t b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pad_bridge_fifo.sv
`default_nettype none
// ==========================================================================
// pad_bridge_fifo : synchronous FIFO, combinational head read, async reset.
//                                                               Rev 1.0
// ==========================================================================
module pad_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // The extra pointer bit distinguishes full from empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH);

endmodule
`default_nettype wire

// File: rtl/pad_handshake_bridge.sv
`default_nettype none
// ==========================================================================
// pad_handshake_bridge : 4-phase req/ack pad ports to valid/ready byte
// streams. Odd parity checking/generation when PAD_BRIDGE_PARITY_EN is set.
//                                                               Rev 1.0
// ==========================================================================
module pad_handshake_bridge
  import pad_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PAD_W-1:0] ui_pad2core_i,
  output logic [PAD_W-1:0] uo_core2pad_o,
  output byte_t            rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  input  byte_t            tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             parity_err_o,
  output logic [7:0]       err_cnt_o
);

  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d, ack_sync_q, ack_sync_d;
  logic                   req_s, ack_s;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    if (i == 0) begin : g_first
      assign req_sync_d[i] = ui_pad2core_i[RX_REQ_BIT];
      assign ack_sync_d[i] = ui_pad2core_i[TX_ACK_BIT];
    end else begin : g_chain
      assign req_sync_d[i] = req_sync_q[i-1];
      assign ack_sync_d[i] = ack_sync_q[i-1];
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  byte_t     tx_data_q, tx_data_d, rx_byte, fifo_head;
  logic      tx_par_q, tx_par_d, tx_par_new, rdy_en_q, rdy_en_d;
  logic      rx_take, par_bad, fifo_push, fifo_empty, fifo_full;
  logic      unused_pad;

  assign rx_byte = ui_pad2core_i[RX_DATA_LSB +: 8];
  assign rx_take = (rx_state_q == R_IDLE) && req_s && !fifo_full;

  always_comb begin
    rx_state_d = rx_state_q;
    fifo_push  = 1'b0;
    case (rx_state_q)
      R_SYNC: if (!req_s) rx_state_d = R_IDLE;
      R_IDLE: if (rx_take) begin
        fifo_push  = !par_bad;
        rx_state_d = R_ACK;
      end
      R_ACK:  if (!req_s) rx_state_d = R_IDLE;
      default: rx_state_d = R_SYNC;
    endcase
  end

  assign tx_ready_o = rdy_en_q && (tx_state_q == T_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    rdy_en_d   = 1'b1;
    case (tx_state_q)
      T_IDLE:  if (tx_valid_i && tx_ready_o) begin
        tx_data_d  = tx_data_i;
        tx_par_d   = tx_par_new;
        tx_state_d = T_SETUP;
      end
      T_SETUP: tx_state_d = T_REQ;
      T_REQ:   if (ack_s) tx_state_d = T_REL;
      T_REL:   if (!ack_s) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Request synchronisers reset to "asserted" so a req held across reset
  // is not mistaken for a fresh one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync_q <= '1;
      ack_sync_q <= '0;
      rx_state_q <= R_SYNC;
      tx_state_q <= T_IDLE;
      tx_data_q  <= '0;
      tx_par_q   <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      req_sync_q <= req_sync_d;
      ack_sync_q <= ack_sync_d;
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_par_q   <= tx_par_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

`ifdef PAD_BRIDGE_PARITY_EN
  logic  perr_q, perr_d;
  byte_t err_cnt_q, err_cnt_d;

  assign par_bad    = ui_pad2core_i[PAR_BIT] != odd_parity(rx_byte);
  assign tx_par_new = odd_parity(tx_data_i);

  always_comb begin
    perr_d    = perr_q;
    err_cnt_d = err_cnt_q;
    if (rx_take && par_bad) begin
      perr_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      perr_q    <= perr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign parity_err_o = perr_q;
  assign err_cnt_o    = err_cnt_q;
  assign unused_pad   = ^ui_pad2core_i[PAD_W-1:UNUSED_LSB];
`else
  assign par_bad      = 1'b0;
  assign tx_par_new   = 1'b0;
  assign parity_err_o = 1'b0;
  assign err_cnt_o    = '0;
  assign unused_pad   = ^{ui_pad2core_i[PAD_W-1:UNUSED_LSB], ui_pad2core_i[PAR_BIT]};
`endif

  pad_bridge_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (rx_byte),
    .pop_i   (rx_valid_o && rx_ready_i),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rx_data_o  = fifo_head;
  assign rx_valid_o = !fifo_empty;

  always_comb begin
    uo_core2pad_o                       = '0;
    uo_core2pad_o[TX_DATA_LSB +: 8]     = tx_data_q;
    uo_core2pad_o[TX_REQ_BIT]           = (tx_state_q == T_REQ);
    uo_core2pad_o[RX_ACK_BIT]           = (rx_state_q == R_ACK);
    uo_core2pad_o[PAR_BIT]              = tx_par_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pad_handshake_bridge.sv
`default_nettype none
// Bench for pad_handshake_bridge: queue-based behavioural model checked every
// cycle, directed protocol scenarios with literal expectations, random traffic.
module tb_pad_handshake_bridge;

  localparam int D = 4;
  localparam int S = 2;
`ifdef PAD_BRIDGE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_dat = '0;
  logic        rx_req = 1'b0, rx_par = 1'b0, tx_ack = 1'b0;
  logic [5:0]  junk = '0;
  logic [16:0] ui, uo;
  logic [7:0]  rx_data, tx_data = '0, ecnt;
  logic        rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready, perr;
  bit          dev_auto = 1'b0, man_ack = 1'b0, rx_done = 1'b0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;
  assign ui = {junk, rx_par, tx_ack, rx_req, rx_dat};

  pad_handshake_bridge #(.FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ui_pad2core_i(ui), .uo_core2pad_o(uo),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .parity_err_o(perr), .err_cnt_o(ecnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (updated on each active edge) --------
  logic [7:0]   mq[$];
  bit           m_armed = 0, m_ack = 0, m_started = 0, m_perr = 0, m_txp = 0;
  int           m_ph = 0, m_ecnt = 0;   // tx phase: 0 idle,1 setup,2 req,3 release
  logic [7:0]   m_txd = '0;
  logic [S-1:0] rh = '1, ah = '0;        // pad control history, [S-1] = synced
  bit           rs, a_s, bad_p;
  int           sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_armed = 0; m_ack = 0; m_started = 0; m_perr = 0; m_txp = 0;
      m_ph = 0; m_ecnt = 0; m_txd = '0; rh = '1; ah = '0;
    end else begin
      rs = rh[S-1]; a_s = ah[S-1]; sz = mq.size();
      bad_p = PAR_EN && (ui[10] !== ~^ui[7:0]);
      if (sz > 0 && rx_ready) void'(mq.pop_front());
      if (!m_armed) m_armed = !rs;
      else if (!m_ack) begin
        if (rs && sz < D) begin
          m_ack = 1;
          if (bad_p) begin
            m_perr = 1;
            if (m_ecnt < 255) m_ecnt++;
          end else mq.push_back(ui[7:0]);
        end
      end else if (!rs) m_ack = 0;
      case (m_ph)
        0: if (tx_valid && m_started) begin
             m_txd = tx_data; m_txp = PAR_EN ? ~^tx_data : 1'b0; m_ph = 1;
           end
        1: m_ph = 2;
        2: if (a_s) m_ph = 3;
        default: if (!a_s) m_ph = 0;
      endcase
      m_started = 1;
      rh = {rh[S-2:0], ui[8]};
      ah = {ah[S-2:0], ui[9]};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rx_valid", rx_valid, mq.size() > 0);
      if (mq.size() > 0) chk("rx_data", rx_data, mq[0]);
      chk("rx_ack", uo[9], m_ack);
      chk("tx_req", uo[8], m_ph == 2);
      chk("tx_data", uo[7:0], m_txd);
      chk("tx_par", uo[10], m_txp);
      chk("uo_unused", uo[16:11], 0);
      chk("tx_ready", tx_ready, (m_ph == 0) && m_started);
      chk("parity_err", perr, m_perr);
      chk("err_cnt", ecnt, m_ecnt);
    end
  end

  // Transmit-side host: manual ack, or random-delay automatic responder.
  initial forever begin
    @(negedge clk); #2;
    if (!dev_auto) tx_ack = man_ack;
    else if (uo[8] && !tx_ack) begin
      if ($urandom_range(0, 2) == 0) tx_ack = 1'b1;
    end else if (!uo[8] && tx_ack) begin
      if ($urandom_range(0, 2) == 0) tx_ack = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic wait_ack(input logic lvl, input int bound, output int lat);
    lat = 0;
    while (uo[9] !== lvl && lat < bound) begin tick(); lat++; end
  endtask

  task automatic send(input logic [7:0] d, input logic p, output int lat);
    int n;
    rx_dat = d; rx_par = p; junk = 6'($urandom);
    tick();
    rx_req = 1'b1;
    wait_ack(1'b1, 300, lat);
    chk("rx_ack_rise", uo[9], 1);
    rx_req = 1'b0;
    wait_ack(1'b0, 50, n);
    chk("rx_ack_fall", uo[9], 0);
  endtask

  initial begin
    int lat, n, lat_r;
    logic [7:0] d;
    rx_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_perr", perr, 0);
    chk("rst_ecnt", ecnt, 0);
    #1 rst_n = 1'b1;
    repeat (8) tick();
    chk("held_req_no_ack", uo[9], 0);
    chk("held_req_no_push", rx_valid, 0);
    rx_req = 1'b0;
    repeat (4) tick();
    send(8'h11, ~^8'h11, lat);
    chk("rearm_data", rx_data, 8'h11);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;

    send(8'hA5, ~^8'hA5, lat);
    chk("a5_latency", lat, 3);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      d = 8'(k);
      send(d, ~^d, lat);
    end
    rx_dat = 8'h05; rx_par = ~^8'h05; tick();
    rx_req = 1'b1;
    wait_ack(1'b1, 20, lat);
    chk("full_backpressure", uo[9], 0);
    chk("full_head", rx_data, 8'h01);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    wait_ack(1'b1, 20, lat);
    chk("fifth_ack", uo[9], 1);
    rx_req = 1'b0;
    wait_ack(1'b0, 20, lat);
    rx_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("drain_order", rx_data, k);
      tick();
    end
    rx_ready = 1'b0;
    chk("drained", rx_valid, 0);

    send(8'h21, ~^8'h21, lat);
    send(8'h22, ~^8'h22, lat);
    rx_dat = 8'h23; rx_par = ~^8'h23; tick();
    rx_req = 1'b1; tick(); tick();
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("pp_ack", uo[9], 1);
    chk("pp_head", rx_data, 8'h22);
    rx_req = 1'b0;
    wait_ack(1'b0, 20, lat);
    rx_ready = 1'b1;
    chk("pp_order0", rx_data, 8'h22); tick();
    chk("pp_order1", rx_data, 8'h23); tick();
    rx_ready = 1'b0;
    chk("pp_empty", rx_valid, 0);

    tx_data = 8'h3C; tx_valid = 1'b1; n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("tx_idle_ready", tx_ready, 1);
    tick();
    tx_data = 8'h55;
    chk("tx_setup_data", uo[7:0], 8'h3C);
    chk("tx_setup_req", uo[8], 0);
    chk("tx_busy", tx_ready, 0);
    tick();
    chk("tx_req_rise", uo[8], 1);
    repeat (4) tick();
    chk("tx_req_held", uo[8], 1);
    chk("tx_holdoff", tx_ready, 0);
    man_ack = 1'b1; n = 0;
    while (uo[8] && n < 20) begin tick(); n++; end
    chk("tx_req_drop", uo[8], 0);
    chk("tx_rel_busy", tx_ready, 0);
    man_ack = 1'b0; n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("tx_ready_latency", n, 3);
    tick();
    tx_valid = 1'b0;
    chk("tx_second_data", uo[7:0], 8'h55);
    dev_auto = 1'b1;

`ifdef PAD_BRIDGE_PARITY_EN
    send(8'h07, 1'b1, lat);
    chk("par_no_push", rx_valid, 0);
    chk("par_err_flag", perr, 1);
    chk("par_err_cnt1", ecnt, 1);
    repeat (300) begin
      d = 8'($urandom);
      send(d, ^d, lat);
    end
    chk("par_err_sat", ecnt, 255);
    chk("par_err_sticky", perr, 1);
`endif

    fork
      begin
        for (int i = 0; i < 60; i++) begin
          d = 8'($urandom);
          repeat ($urandom_range(0, 3)) tick();
          send(d, (~^d) ^ ($urandom_range(0, 5) == 0), lat_r);
        end
        rx_done = 1'b1;
      end
      begin
        while (!rx_done) begin rx_ready = 1'($urandom_range(0, 1)); tick(); end
        rx_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int w;
          tx_data = 8'($urandom); tx_valid = 1'b1; w = 0;
          while (!tx_ready && w < 100) begin tick(); w++; end
          chk("tx_accept", tx_ready, 1);
          tick();
          tx_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
      end
    join
    repeat (20) tick();
    chk("final_drain", rx_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
